// File: rtl/alu_seq_muldiv_if.sv
// Bus between the EX-stage operand muxes and the sequential ALU.
// Signals:
//   in_valid/in_ready    operand handshake (core -> ALU)
//   in0, in1, ALUCtrl    operands and operation select
//   out_valid/out_ready  result handshake (ALU -> core)
//   ALUOut, Zero         result and its zero flag
//   busy                 stall hint while a long op iterates
// master = core side, slave = ALU side.
interface alu_seq_muldiv_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in0;
    logic [WIDTH-1:0]  in1;
    logic [CTRL_W-1:0] ALUCtrl;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  ALUOut;
    logic              Zero;
    logic              busy;

    modport master (
        output in_valid, in0, in1, ALUCtrl, out_ready,
        input  in_ready, out_valid, ALUOut, Zero, busy
    );

    modport slave (
        input  in_valid, in0, in1, ALUCtrl, out_ready,
        output in_ready, out_valid, ALUOut, Zero, busy
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Sequential ALU for the multi-cycle core EX stage.
// Single-cycle ops (logic, add/sub, compares, shifts) return one cycle after
// accept; MUL/MULHU/DIVU/REMU iterate one shift-add / restoring-subtract step
// per cycle for WIDTH cycles and return WIDTH+1 cycles after accept.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   alu_seq_muldiv_if.slave (operand/result handshakes, busy hint)
module alu_seq_muldiv #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    alu_seq_muldiv_if.slave bus
);
    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [CTRL_W-1:0] OP_AND   = 4'b0000;
    localparam logic [CTRL_W-1:0] OP_OR    = 4'b0001;
    localparam logic [CTRL_W-1:0] OP_ADD   = 4'b0010;
    localparam logic [CTRL_W-1:0] OP_XOR   = 4'b0011;
    localparam logic [CTRL_W-1:0] OP_SLL   = 4'b0100;
    localparam logic [CTRL_W-1:0] OP_SRL   = 4'b0101;
    localparam logic [CTRL_W-1:0] OP_SUB   = 4'b0110;
    localparam logic [CTRL_W-1:0] OP_SLT   = 4'b0111;
    localparam logic [CTRL_W-1:0] OP_SLTU  = 4'b1000;
    localparam logic [CTRL_W-1:0] OP_MUL   = 4'b1001;
    localparam logic [CTRL_W-1:0] OP_MULHU = 4'b1010;
    localparam logic [CTRL_W-1:0] OP_DIVU  = 4'b1011;
    localparam logic [CTRL_W-1:0] OP_NOR   = 4'b1100;
    localparam logic [CTRL_W-1:0] OP_SRA   = 4'b1101;
    localparam logic [CTRL_W-1:0] OP_REMU  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CTRL_W-1:0] op_r, op_nxt_s;
    // hi/lo hold {partial product, multiplier} or {remainder, quotient}.
    logic [WIDTH-1:0]  hi_r, hi_nxt_s;
    logic [WIDTH-1:0]  lo_r, lo_nxt_s;
    // Multiplicand or divisor.
    logic [WIDTH-1:0]  opb_r, opb_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]  alu_out_r, alu_out_nxt_s;
    logic              zero_r, zero_nxt_s;
    logic              in_ready_r, out_valid_r, busy_r;

    logic [WIDTH-1:0]  alu_s;
    logic              is_long_s;
    logic              is_mul_s;
    logic [SHW-1:0]    shamt_s;
    logic [WIDTH:0]    mul_sum_s;
    logic [WIDTH:0]    div_shift_s;
    logic [WIDTH:0]    div_diff_s;
    logic              div_ok_s;
    logic [WIDTH-1:0]  step_hi_s, step_lo_s;
    logic [WIDTH-1:0]  long_res_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.ALUOut    = alu_out_r;
    assign bus.Zero      = zero_r;

    assign shamt_s = bus.in1[SHW-1:0];

    // Single-cycle result and op classification, taken straight from the bus.
    always_comb begin
        alu_s     = {WIDTH{1'b0}};
        is_long_s = 1'b0;
        is_mul_s  = 1'b0;
        case (bus.ALUCtrl)
            OP_AND:   alu_s = bus.in0 & bus.in1;
            OP_OR:    alu_s = bus.in0 | bus.in1;
            OP_ADD:   alu_s = bus.in0 + bus.in1;
            OP_SUB:   alu_s = bus.in0 - bus.in1;
            OP_SLT:   alu_s = {{(WIDTH-1){1'b0}}, ($signed(bus.in0) < $signed(bus.in1))};
            OP_SLTU:  alu_s = {{(WIDTH-1){1'b0}}, (bus.in0 < bus.in1)};
            OP_NOR:   alu_s = ~(bus.in0 | bus.in1);
            OP_XOR:   alu_s = bus.in0 ^ bus.in1;
            OP_SLL:   alu_s = bus.in0 << shamt_s;
            OP_SRL:   alu_s = bus.in0 >> shamt_s;
            OP_SRA:   alu_s = $unsigned($signed(bus.in0) >>> shamt_s);
            OP_MUL:   begin is_long_s = 1'b1; is_mul_s = 1'b1; end
            OP_MULHU: begin is_long_s = 1'b1; is_mul_s = 1'b1; end
            OP_DIVU:  is_long_s = 1'b1;
            OP_REMU:  is_long_s = 1'b1;
            default:  alu_s = {WIDTH{1'b0}};
        endcase
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    // A zero divisor always "fits", yielding all-ones quotient and remainder=in0.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        div_ok_s    = ~div_diff_s[WIDTH];
        if ((op_r == OP_MUL) || (op_r == OP_MULHU)) begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end else begin
            step_hi_s = div_ok_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
            step_lo_s = {lo_r[WIDTH-2:0], div_ok_s};
        end
        // Product low half and quotient both end up in lo; high half and remainder in hi.
        case (op_r)
            OP_MUL:  long_res_s = step_lo_s;
            OP_DIVU: long_res_s = step_lo_s;
            default: long_res_s = step_hi_s;
        endcase
    end

    // FSM next state and datapath register updates.
    always_comb begin
        state_nxt_s   = state_r;
        op_nxt_s      = op_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        opb_nxt_s     = opb_r;
        cnt_nxt_s     = cnt_r;
        alu_out_nxt_s = alu_out_r;
        zero_nxt_s    = zero_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    op_nxt_s = bus.ALUCtrl;
                    if (is_long_s) begin
                        state_nxt_s = ST_BUSY;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        hi_nxt_s    = {WIDTH{1'b0}};
                        lo_nxt_s    = is_mul_s ? bus.in1 : bus.in0;
                        opb_nxt_s   = is_mul_s ? bus.in0 : bus.in1;
                    end else begin
                        state_nxt_s   = ST_DONE;
                        alu_out_nxt_s = alu_s;
                        zero_nxt_s    = (alu_s == {WIDTH{1'b0}});
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                hi_nxt_s  = step_hi_s;
                lo_nxt_s  = step_lo_s;
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = ST_DONE;
                    alu_out_nxt_s = long_res_s;
                    zero_nxt_s    = (long_res_s == {WIDTH{1'b0}});
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= {CTRL_W{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            opb_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            alu_out_r   <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            op_r        <= op_nxt_s;
            hi_r        <= hi_nxt_s;
            lo_r        <= lo_nxt_s;
            opb_r       <= opb_nxt_s;
            cnt_r       <= cnt_nxt_s;
            alu_out_r   <= alu_out_nxt_s;
            zero_r      <= zero_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_BUSY);
        end
    end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed-vector bench for alu_seq_muldiv (WIDTH=32).
module tb_alu_seq_muldiv;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    alu_seq_muldiv_if #(.WIDTH(32), .CTRL_W(4)) bus ();

    alu_seq_muldiv #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, wait (bounded) for the result, check value/Zero/latency, then release it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int cyc;
        int stall_bad;
        chk({tag, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.ALUCtrl  = op;
        bus.in0      = a;
        bus.in1      = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in0      = $urandom;
        bus.in1      = $urandom;
        bus.ALUCtrl  = 4'($urandom);
        cyc       = 1;
        stall_bad = 0;
        while (!bus.out_valid && cyc < 200) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) stall_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "/ALUOut"}, bus.ALUOut, exp);
        chk({tag, "/Zero"}, {31'd0, bus.Zero}, {31'd0, (exp == 32'd0)});
        if (exp_lat > 1) chk({tag, "/stall"}, 32'(stall_bad), 32'd0);
        else             chk({tag, "/busy"}, {31'd0, bus.busy}, 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int bad;
        logic [31:0] held;
        n_vec = 0;
        n_err = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in0       = 32'd0;
        bus.in1       = 32'd0;
        bus.ALUCtrl   = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst/in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst/out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst/ALUOut",    bus.ALUOut,             32'd0);
        chk("rst/Zero",      {31'd0, bus.Zero},      32'd0);
        chk("rst/busy",      {31'd0, bus.busy},      32'd0);

        run_op("and",  4'b0000, 32'd10, 32'd20, 32'd0,          1);
        run_op("or",   4'b0001, 32'd10, 32'd20, 32'd30,         1);
        run_op("add",  4'b0010, 32'd10, 32'd20, 32'd30,         1);
        run_op("sub",  4'b0110, 32'd10, 32'd20, 32'hFFFFFFF6,   1);
        run_op("slt",  4'b0111, 32'd10, 32'd20, 32'd1,          1);
        run_op("nor",  4'b1100, 32'd10, 32'd20, 32'hFFFFFFE1,   1);
        run_op("xor",  4'b0011, 32'd10, 32'd20, 32'd30,         1);
        run_op("slts", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1,     1);
        run_op("sltu", 4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0,     1);
        run_op("sll",  4'b0100, 32'h80000000, 32'h24, 32'd0,        1);
        run_op("srl",  4'b0101, 32'h80000000, 32'h24, 32'h08000000, 1);
        run_op("sra",  4'b1101, 32'h80000000, 32'h24, 32'hF8000000, 1);
        run_op("op15", 4'b1111, 32'd5, 32'd3, 32'd0,            1);

        run_op("mul",    4'b1001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
        run_op("mulhu",  4'b1010, 32'hFFFFFFFF, 32'd2, 32'd1,        33);
        run_op("mulhu2", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("divu",   4'b1011, 32'd100, 32'd7, 32'd14,         33);
        run_op("remu",   4'b1110, 32'd100, 32'd7, 32'd2,          33);
        run_op("divu0",  4'b1011, 32'd5, 32'd0, 32'hFFFFFFFF,     33);
        run_op("remu0",  4'b1110, 32'd5, 32'd0, 32'd5,            33);

        // Backpressure: result held in DONE, competing op ignored until IDLE.
        bus.in_valid = 1'b1; bus.ALUCtrl = 4'b0010; bus.in0 = 32'd3; bus.in1 = 32'd4;
        @(posedge clk); #1;
        bus.ALUCtrl = 4'b0110; bus.in0 = 32'd9; bus.in1 = 32'd4;
        chk("bp/ALUOut", bus.ALUOut, 32'd7);
        held = bus.ALUOut;
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.ALUOut !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        chk("bp/hold", 32'(bad), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp/idle_ready", {31'd0, bus.in_ready},  32'd1);
        chk("bp/idle_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp/new_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp/new_ALUOut", bus.ALUOut, 32'd5);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset in the middle of a divide aborts it.
        bus.in_valid = 1'b1; bus.ALUCtrl = 4'b1011; bus.in0 = 32'd100; bus.in1 = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort/out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort/in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("abort/ALUOut",    bus.ALUOut,             32'd0);
        chk("abort/busy",      {31'd0, bus.busy},      32'd0);
        rst = 1'b0;
        run_op("post_rst_add", 4'b0010, 32'd1, 32'd1, 32'd2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
